cla_adder32_pipe: RTL and testbench
===================================

// Module: cla_adder32_pipe
// PURPOSE
//  32-bit two-stage pipelined carry-lookahead adder/subtractor for the miniRISC ALU datapath.
//  Stage 1 forms per-bit generate/propagate and 4-bit group G/P.
//  Stage 2 feeds those group signals into two-level lookahead carry logic and produces sum and flags.
//  Sits between the ALU operand mux (upstream) and the ALU result mux (downstream); valid/ready on both sides.
// PARAMETERS
//  WIDTH   32  operand width; fixed at 32, must be a multiple of 16
//  GROUP   4   bits per lookahead group; fixed at 4
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   operands/op presented
//  in_ready   out  1   block accepts operands this cycle
//  a          in   32  operand A
//  b          in   32  operand B
//  sub        in   1   1 = A-B (B inverted, cin forced 1); 0 = A+B+cin
//  cin        in   1   carry-in, used only when sub=0
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  sum        out  32  result
//  cout       out  1   carry out of bit 31 (for sub: 1 = no borrow)
//  ovf        out  1   signed overflow: carry into bit31 XOR carry out of bit31
//  zero       out  1   sum == 0
//  neg        out  1   sum[31]
// BEHAVIOUR
//  - Reset: s1_valid=0, s2_valid=0; out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0; in_ready=1 in the first cycle after reset.
//  - Stage 1 capture:
//    - b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
//    - Register p=a^b_eff, g=a&b_eff, c0.
//    - Register the 8 group (Gk,Pk) pairs from the 4-bit group formulas.
//  - Stage 2 capture:
//    - Second-level lookahead over groups 0-3 and 4-7 (two 16-bit super-groups).
//    - Super-group carry chained: c16 = G_hi0 | P_hi0&c0.
//    - Group carries feed the per-bit carries; sum = p ^ c[31:0].
//    - Register sum and flags.
//  - Latency: exactly 2 cycles from accept (in_valid&in_ready) to out_valid with out_ready held high.
//  - Throughput: 1 result/cycle.
//  - Advance rules:
//    - adv2 = s1_valid & (!s2_valid | out_ready).
//    - adv1 = in_valid & in_ready.
//    - in_ready = !s1_valid | adv2 (combinational from out_ready; no register bubble).
//  - Holding:
//    - Output regs hold stable while out_valid & !out_ready; no value change, no drop.
//    - s1 holds while stalled.
//  - Simultaneous events:
//    - s2 drains and s1 moves up in the same cycle -> s1 may accept a new op in that cycle.
//    - in_valid with in_ready=0 -> ignored; the source must hold.
//  - Full: both stages valid and out_ready=0 -> in_ready=0.
//  - Empty: out_valid=0; sum and flags keep their last values (don't-care to consumer).
//  - Reset mid-operation: all in-flight ops discarded; no output pulse afterwards.
//  - Arithmetic is modulo 2^32.
//    - cout is the true carry.
//    - ovf uses carries c31 and c32.
//    - zero/neg computed from the registered sum in the same stage.
// STRUCTURE
//  - Shared package (alu_pkg):
//    - ALU_W=32 and LCU_GRP=4.
//    - Flag bit indices (FLG_C=0, FLG_V=1, FLG_Z=2, FLG_N=3).
//    - Function grp_gp(g4,p4) -> {G,P}.
//  - One natural sub-module: lcu4_level.
//    - Inputs: 4 (G,P) pairs + cin.
//    - Outputs: 4 carries + group G/P.
//    - Used at bit level (x8) and at group level (x2), all in stage 2.
//  - Top holds only the pipeline registers, handshake logic and flag logic.
// TESTING
//  1. Add: a=0x0000_0001, b=0xFFFF_FFFF, sub=0, cin=0 -> sum=0, cout=1, ovf=0, zero=1, neg=0, two cycles after accept.
//  2. Signed overflow: a=0x7FFF_FFFF, b=1, add -> sum=0x8000_0000, ovf=1, neg=1, cout=0.
//  3. Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, neg=1. Then a=7, b=5 -> sum=2, cout=1.
//  4. Back-pressure: stream 4 ops with out_ready=0 from cycle 2.
//     - in_ready drops after 2 accepts.
//     - Releasing out_ready delivers all 4 in order, none lost or duplicated.
//  5. Full-carry ripple: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1 (checks the c16 super-group chain).
//  6. Reset mid-flight: assert rst with both stages valid -> out_valid=0 next cycle; no stale result after release.
//  - Random: 10k random ops against a behavioural {cout,sum}=a+b_eff+c0 model with random out_ready.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants, pipeline payload types and the 4-bit lookahead group function.
// Imported by the CLA adder and its lookahead sub-module.
package alu_pkg;

   localparam int ALU_W   = 32;
   localparam int LCU_GRP = 4;
   localparam int NGRP    = ALU_W / LCU_GRP;

   localparam int FLG_C = 0;
   localparam int FLG_V = 1;
   localparam int FLG_Z = 2;
   localparam int FLG_N = 3;

   // Stage-1 payload: per-bit generate/propagate, per-group G/P and the carry-in
   typedef struct packed {
      logic [ALU_W-1:0] p;
      logic [ALU_W-1:0] g;
      logic [NGRP-1:0]  gg;
      logic [NGRP-1:0]  gp;
      logic             c0;
   } s1_t;

   function automatic logic [1:0] grp_gp(input logic [3:0] g4, input logic [3:0] p4);
      logic gg;
      logic pp;
      gg = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0]);
      pp = &p4;
      return {gg, pp};
   endfunction

endpackage

// File: rtl/lcu4_level.sv
// 4-wide lookahead carry unit: carries out of each position plus group G/P.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure logic.
module lcu4_level
   import alu_pkg::*;
(
   input  logic [3:0] g,
   input  logic [3:0] p,
   input  logic       ci,
   output logic [3:0] c,
   output logic       gout,
   output logic       pout
);

   // c[i] is the carry out of position i, all expanded flat from ci
   always_comb begin
      c[0] = g[0] | (p[0] & ci);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
   end

   assign {gout, pout} = grp_gp(g, p);

endmodule

// File: rtl/cla_adder32_pipe.sv
// Two-stage pipelined 32-bit carry-lookahead adder/subtractor with C/V/Z/N flags.
// Latency: 2 cycles from accept to out_valid; 1 result per cycle.
// Backpressure: valid/ready; in_ready = !s1_valid | adv2, output registers hold while stalled.
module cla_adder32_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W,
   parameter int GROUP = LCU_GRP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NG = WIDTH / GROUP;

   logic             s1_valid;
   logic             s2_valid;
   logic             adv1;
   logic             adv2;
   s1_t              s1_d;
   s1_t              s1_q;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p_d;
   logic [WIDTH-1:0] g_d;
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;
   logic [3:0]       flg_d;
   logic [3:0]       flg_q;

   assign adv2     = s1_valid & (~s2_valid | out_ready);
   assign in_ready = ~s1_valid | adv2;
   assign adv1     = in_valid & in_ready;

   // Stage 1: subtract is A + ~B + 1, so fold the inversion into b_eff here
   always_comb begin
      b_eff   = sub ? ~b : b;
      p_d     = a ^ b_eff;
      g_d     = a & b_eff;
      s1_d    = '0;
      s1_d.p  = p_d;
      s1_d.g  = g_d;
      s1_d.c0 = sub | cin;
      for (int k = 0; k < NG; k++) begin
         {s1_d.gg[k], s1_d.gp[k]} = grp_gp(g_d[4*k +: 4], p_d[4*k +: 4]);
      end
   end

   // Stage 2: group-level lookahead over each 16-bit half, chained through c16
   logic [2:0]       gc_lo;
   logic [3:0]       gc_hi;
   logic             sg_g_lo;
   logic             sg_p_lo;
   logic             c16;
   logic [NG-1:0]    gcin;
   logic [3*NG-1:0]  bco;
   logic [WIDTH-1:0] cvec;
   logic             unused_lo_c3;
   logic             unused_hi_g;
   logic             unused_hi_p;
   logic [NG-1:0]    unused_bco;
   logic [NG-1:0]    unused_bg;
   logic [NG-1:0]    unused_bp;

   lcu4_level u_grp_lo (
      .g    (s1_q.gg[3:0]),
      .p    (s1_q.gp[3:0]),
      .ci   (s1_q.c0),
      .c    ({unused_lo_c3, gc_lo}),
      .gout (sg_g_lo),
      .pout (sg_p_lo)
   );

   assign c16 = sg_g_lo | (sg_p_lo & s1_q.c0);

   lcu4_level u_grp_hi (
      .g    (s1_q.gg[7:4]),
      .p    (s1_q.gp[7:4]),
      .ci   (c16),
      .c    (gc_hi),
      .gout (unused_hi_g),
      .pout (unused_hi_p)
   );

   assign gcin = {gc_hi[2:0], c16, gc_lo, s1_q.c0};

   for (genvar k = 0; k < NG; k++) begin : g_bit
      lcu4_level u_bit (
         .g    (s1_q.g[4*k +: 4]),
         .p    (s1_q.p[4*k +: 4]),
         .ci   (gcin[k]),
         .c    ({unused_bco[k], bco[3*k +: 3]}),
         .gout (unused_bg[k]),
         .pout (unused_bp[k])
      );
      assign cvec[4*k +: 4] = {bco[3*k +: 3], gcin[k]};
   end

   // cvec[i] is the carry into bit i; c32 comes from the group-level chain
   always_comb begin
      sum_d        = s1_q.p ^ cvec;
      flg_d        = '0;
      flg_d[FLG_C] = gc_hi[3];
      flg_d[FLG_V] = cvec[WIDTH-1] ^ gc_hi[3];
      flg_d[FLG_Z] = ~|sum_d;
      flg_d[FLG_N] = sum_d[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_q     <= '0;
         sum_q    <= '0;
         flg_q    <= '0;
      end else begin
         if (adv1) s1_q <= s1_d;
         s1_valid <= adv1 | (s1_valid & ~adv2);
         if (adv2) begin
            sum_q <= sum_d;
            flg_q <= flg_d;
         end
         s2_valid <= adv2 | (s2_valid & ~out_ready);
      end
   end

   assign out_valid = s2_valid;
   assign sum       = sum_q;
   assign cout      = flg_q[FLG_C];
   assign ovf       = flg_q[FLG_V];
   assign zero      = flg_q[FLG_Z];
   assign neg       = flg_q[FLG_N];

endmodule

// File: tb/tb_cla_adder32_pipe.sv
// Scoreboard bench for cla_adder32_pipe: directed corner ops, back-pressure, reset and random traffic.
module tb_cla_adder32_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;
   logic        neg;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   n_acc   = 0;
   int   or_mode = 1;  // 0: out_ready low, 1: high, 2: random
   logic        held_vld = 1'b0;
   logic [35:0] held;

   always #5 clk = ~clk;

   cla_adder32_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic exp_t mk(input logic [31:0] s, input logic c, v, z, n);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = v; e.zero = z; e.neg = n;
      return e;
   endfunction

   // Reference: plain 33-bit arithmetic; overflow from operand/result signs
   function automatic exp_t model(input logic [31:0] aa, bb, input logic s, ci);
      logic [31:0] be;
      logic [32:0] t;
      exp_t        e;
      be     = s ? ~bb : bb;
      t      = {1'b0, aa} + {1'b0, be} + {32'd0, (s ? 1'b1 : ci)};
      e.sum  = t[31:0];
      e.cout = t[32];
      e.ovf  = (aa[31] == be[31]) && (e.sum[31] != aa[31]);
      e.zero = (e.sum == 32'd0);
      e.neg  = e.sum[31];
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic send(input logic [31:0] aa, bb, input logic s, ci, input exp_t e);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1; a = aa; b = bb; sub = s; cin = ci;
      forever begin
         #4;
         if (in_ready) begin
            @(posedge clk);
            sb.push_back(e);
            n_acc++;
            #1 in_valid = 1'b0;
            break;
         end
         @(posedge clk);
         waited++;
         if (waited > 500) begin
            fail("send_timeout");
            #1 in_valid = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int n = 0;
      or_mode = 1;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail("drain_timeout");
      repeat (2) @(negedge clk);
   endtask

   // Monitor: drives out_ready, pops the scoreboard on each transfer, checks hold stability
   initial begin
      exp_t e;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #4;
         if (rst) begin
            held_vld = 1'b0;
         end else begin
            if (held_vld)
               chk("hold_stable", {out_valid, sum, cout, ovf, zero, neg}, {1'b1, held});
            held_vld = 1'b0;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  fail("spurious_output");
               end else begin
                  e = sb.pop_front();
                  chk("sum", sum, e.sum);
                  chk("flags_cvzn", {cout, ovf, zero, neg}, {e.cout, e.ovf, e.zero, e.neg});
               end
            end else if (out_valid) begin
               held_vld = 1'b1;
               held     = {sum, cout, ovf, zero, neg};
            end
         end
      end
   end

   initial begin
      int n0;
      logic [31:0] ra, rb;
      logic        rs, rc;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_sum", sum, 32'h0);
      chk("reset_flags", {cout, ovf, zero, neg}, 4'h0);
      chk("reset_in_ready", in_ready, 1'b1);

      // add wrapping to zero, with exact latency
      send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
      @(negedge clk); #4;
      chk("latency_cycle1", out_valid, 1'b0);
      @(negedge clk); #4;
      chk("latency_cycle2", out_valid, 1'b1);
      drain();

      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1));
      send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0));
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0));
      send(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
      send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0));
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
      send(32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0));
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0));
      drain();

      // back-pressure: two accepts fill the pipe, third must wait
      or_mode = 0;
      repeat (2) @(negedge clk);
      n0 = n_acc;
      send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, mk(32'h0000_3333, 1'b0, 1'b0, 1'b0, 1'b0));
      send(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, mk(32'h0000_000F, 1'b1, 1'b0, 1'b0, 1'b0));
      fork
         send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
         begin
            repeat (3) @(negedge clk);
            #4;
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_accept_count", 64'(n_acc - n0), 64'd2);
            chk("bp_out_valid", out_valid, 1'b1);
            or_mode = 1;
         end
      join
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, mk(32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0));
      drain();
      chk("bp_all_delivered", 64'(sb.size()), 64'd0);

      // reset with both stages occupied
      or_mode = 0;
      repeat (2) @(negedge clk);
      send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, model(32'hAA, 32'h55, 1'b0, 1'b0));
      send(32'h0000_00BB, 32'h0000_0011, 1'b1, 1'b0, model(32'hBB, 32'h11, 1'b1, 1'b0));
      @(negedge clk);
      #1;
      chk("full_in_ready_low", in_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk); #4;
      chk("rst_out_valid", out_valid, 1'b0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      or_mode = 1;
      repeat (6) @(negedge clk);
      #4;
      chk("rst_no_stale", out_valid, 1'b0);

      // random traffic with random out_ready
      or_mode = 2;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         ra = pick();
         rb = pick();
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         send(ra, rb, rs, rc, model(ra, rb, rs, rc));
      end
      drain();
      chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
